// File: rtl/fir_coeff_loader_if.sv
// Coefficient-bank write port, transfer handshake and bit-serial load lines
// between the config logic, the coefficient loader and the FIR filter.
interface fir_coeff_loader_if #(
    parameter int DataWidth = 12,
    parameter int NTaps     = 9
);
    localparam int NCoeffs   = (NTaps + 1) / 2;
    localparam int AddrWidth = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;

    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;
    logic                 send;
    logic                 fir_idle;
    logic                 busy;
    logic                 done;
    logic                 coeff_load;
    logic                 coeff_out;

    modport master (
        output wr_en, wr_addr, wr_data, send, fir_idle,
        input  busy, done, coeff_load, coeff_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, send, fir_idle,
        output busy, done, coeff_load, coeff_out
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Coefficient bank plus serializer feeding the FIR filter's coefficient shift
// chain: last word first, MSB first, so bank[0] LSB lands at the chain entry.
module fir_coeff_loader #(
    parameter int DataWidth = 12,
    parameter int NTaps     = 9
) (
    input  logic               clk,
    input  logic               rstN,
    fir_coeff_loader_if.slave  bus
);
    localparam int NCoeffs   = (NTaps + 1) / 2;
    localparam int AddrWidth = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
    localparam int BitWidth  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int TotalBits = NCoeffs * DataWidth;

    localparam logic [AddrWidth:0]   NCoeffsW = (AddrWidth + 1)'(NCoeffs);
    localparam logic [BitWidth-1:0]  BitMax   = BitWidth'(DataWidth - 1);
    localparam logic [AddrWidth-1:0] WordMax  = AddrWidth'(NCoeffs - 1);

    if ((NTaps % 2) == 0) begin : gBadTaps
        $fatal(1, "fir_coeff_loader: NTaps must be odd");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   bank_q [NCoeffs];
    logic [DataWidth-1:0]   bank_d [NCoeffs];
    logic [TotalBits-1:0]   shiftReg_q, shiftReg_d;
    logic [TotalBits-1:0]   snapshot;
    logic [BitWidth-1:0]    bitCnt_q, bitCnt_d;
    logic [AddrWidth-1:0]   wordCnt_q, wordCnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   coeffLoad_q, coeffLoad_d;
    logic                   coeffOut_q, coeffOut_d;
    logic                   wrHit;

    assign wrHit = bus.wr_en && ({1'b0, bus.wr_addr} < NCoeffsW);

    // The snapshot is taken from the post-write bank so a write coinciding
    // with an accepted send is part of that transfer.
    always_comb begin
        bank_d   = bank_q;
        snapshot = '0;
        if (wrHit) begin
            bank_d[bus.wr_addr] = bus.wr_data;
        end
        for (int i = 0; i < NCoeffs; i++) begin
            snapshot[i*DataWidth +: DataWidth] = bank_d[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        shiftReg_d  = shiftReg_q;
        bitCnt_d    = bitCnt_q;
        wordCnt_d   = wordCnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        coeffLoad_d = 1'b0;
        coeffOut_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    busy_d    = 1'b1;
                    bitCnt_d  = BitMax;
                    wordCnt_d = WordMax;
                    if (bus.fir_idle) begin
                        state_d     = SHIFT;
                        coeffLoad_d = 1'b1;
                        coeffOut_d  = snapshot[TotalBits-1];
                        shiftReg_d  = {snapshot[TotalBits-2:0], 1'b0};
                    end else begin
                        state_d    = WAIT;
                        shiftReg_d = snapshot;
                    end
                end
            end
            WAIT: begin
                if (bus.fir_idle) begin
                    state_d     = SHIFT;
                    coeffLoad_d = 1'b1;
                    coeffOut_d  = shiftReg_q[TotalBits-1];
                    shiftReg_d  = {shiftReg_q[TotalBits-2:0], 1'b0};
                end
            end
            SHIFT: begin
                // Counters name the bit currently on coeff_out.
                if ((bitCnt_q == '0) && (wordCnt_q == '0)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    coeffLoad_d = 1'b1;
                    coeffOut_d  = shiftReg_q[TotalBits-1];
                    shiftReg_d  = {shiftReg_q[TotalBits-2:0], 1'b0};
                    if (bitCnt_q == '0) begin
                        bitCnt_d  = BitMax;
                        wordCnt_d = wordCnt_q - 1'b1;
                    end else begin
                        bitCnt_d = bitCnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            for (int i = 0; i < NCoeffs; i++) begin
                bank_q[i] <= '0;
            end
            shiftReg_q  <= '0;
            bitCnt_q    <= '0;
            wordCnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            coeffLoad_q <= 1'b0;
            coeffOut_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            shiftReg_q  <= shiftReg_d;
            bitCnt_q    <= bitCnt_d;
            wordCnt_q   <= wordCnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            coeffLoad_q <= coeffLoad_d;
            coeffOut_q  <= coeffOut_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.coeff_load = coeffLoad_q;
    assign bus.coeff_out  = coeffOut_q;
endmodule
